pi_loop_filter_gen: RTL and testbench
=====================================

// Module: pi_loop_filter_gen
// PURPOSE
// Parametrised burst-gated PI loop filter for the chroma subcarrier recovery path.
// - Sums the colour-burst phase error over each burst window.
// - Rejects bursts that are too short.
// - Updates a saturating integrator and emits a clamped frequency offset, once per line, to the NCO.
// - Adds runtime gains, hold/clear controls, overflow protection and optional lock detection.
// PARAMETERS
// ERR_W        12  width of signed error_in
// CNT_W         7  width of burst sample counter (max 2^CNT_W-1 samples per burst)
// ACC_W        24  burst accumulator width; must be >= ERR_W+CNT_W
// INT_W        32  integrator width (signed)
// OUT_W        32  offset_out width (signed)
// MIN_SAMPLES   8  bursts with fewer accepted samples are rejected
// LOCK_THRESH  64  |captured error| below this counts as a good line (lock feature)
// LOCK_LINES   16  consecutive good lines required to assert locked
// PORTS
// clk           in   1      system clock
// rst_n         in   1      asynchronous active-low reset
// burst_active  in   1      high while error_in is a valid burst sample
// error_in      in   ERR_W  signed phase error (red/V component during burst)
// kp_shift      in   5      proportional gain = 2^-kp_shift; sampled in S_EVAL
// ki_shift      in   5      integral gain = 2^-ki_shift; sampled in S_EVAL
// hold          in   1      freeze integrator; P term still applied
// clear_int     in   1      synchronous integrator clear
// offset_out    out  OUT_W  signed NCO frequency offset
// offset_valid  out  1      one-cycle pulse when offset_out updates
// burst_reject  out  1      one-cycle pulse when a burst is discarded
// sat_flag      out  1      sticky; set on integrator or output clamp, cleared by clear_int
// locked        out  1      lock indicator (0 when PI_LOOP_LOCK_EN undefined)
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - All outputs 0.
//   - Accumulator, count, integrator and lock counter 0.
//   - State S_IDLE.
//   - Reset mid-burst discards the partial burst.
// - FSM S_IDLE -> S_ACCUM -> S_EVAL -> S_UPDATE -> S_IDLE:
//   - S_IDLE: burst_active=1 -> S_ACCUM; the first sample is accumulated on that edge (acc=error_in, cnt=1).
//   - S_ACCUM: burst_active=1 -> acc+=sext(error_in), cnt+=1.
//     - Once cnt = 2^CNT_W-1, further samples are ignored; acc and cnt hold.
//     - burst_active=0 at edge E0 -> capture acc into cap_err, capture cnt; clear acc/cnt; go to S_EVAL.
//   - S_EVAL (edge E0+1):
//     - cap_cnt < MIN_SAMPLES -> burst_reject=1, go to S_IDLE; no other state changes.
//     - Otherwise latch the gains, update the integrator, go to S_UPDATE.
//   - S_UPDATE (edge E0+2): register offset_out and pulse offset_valid; go to S_IDLE.
//   - burst_active during S_EVAL/S_UPDATE is ignored; the next burst begins from S_IDLE.
// - Integrator update (S_EVAL):
//   - int_next = sat_INT_W(int + sext(cap_err)).
//   - The value is not written if hold=1.
//   - The update uses saturating add.
//   - On clamp: int = +/-(2^(INT_W-1)-1), set sat_flag.
// - Output (S_UPDATE):
//   - p = cap_err >>> kp_shift; i = int >>> ki_shift, using the new integrator value.
//   - offset_out = sat_OUT_W(p + i); a clamp sets sat_flag.
//   - Shifts are arithmetic; shift >= operand width yields 0 or -1.
// - clear_int:
//   - Sets int=0 and sat_flag=0 at the next edge, in any state.
//   - Overrides an integrator update on the same edge.
//   - offset_out is unchanged until the next update.
// - Latency: offset_valid is high in the cycle after edge E0+2; exactly one pulse per accepted burst.
// CONFIGURATION
// PI_LOOP_LOCK_EN defined:
// - In S_EVAL, each accepted burst with |cap_err| < LOCK_THRESH increments the good-line counter (saturates at LOCK_LINES).
// - Any other accepted burst clears the counter and deasserts locked.
// - locked=1 while counter == LOCK_LINES.
// - Rejected bursts do not change the counter.
// - clear_int clears the counter.
// PI_LOOP_LOCK_EN undefined: lock logic is absent; locked is tied to 0.
// TESTING
// - Defaults, kp=4, ki=6, 20 samples of +16: int=320, offset_out=25, offset_valid at E0+2. Repeat: int=640, out=30.
// - 5-sample burst: burst_reject pulse at E0+1; no offset_valid; int unchanged.
// - INT_W=16, repeated 100-sample bursts of +127 (12700 each): third update clamps int=32767, sat_flag=1.
// - hold=1 with the same 20x+16 burst: int stays 320, offset_out = 20 + 5 = 25.
// - clear_int mid-burst: int=0 and sat_flag=0 next edge; burst still completes.
// - rst_n low mid-burst: all 0 immediately; next 20x+16 burst gives offset_out=25.
// - Lock (with PI_LOOP_LOCK_EN): 16 bursts of 10x+2 (cap_err=20) -> locked=1 on the 16th update; one burst with cap_err=100 -> locked=0.

Source files
------------

// File: rtl/pi_loop_filter_gen_if.sv
// Burst-error stream, gain/control inputs and status outputs of pi_loop_filter_gen.
// The master side drives the burst samples and controls; the slave side is the filter.
interface pi_loop_filter_gen_if #(
   parameter int ERR_W = 12,
   parameter int OUT_W = 32
);
   logic                    burst_active;
   logic signed [ERR_W-1:0] error_in;
   logic [4:0]              kp_shift;
   logic [4:0]              ki_shift;
   logic                    hold;
   logic                    clear_int;
   logic signed [OUT_W-1:0] offset_out;
   logic                    offset_valid;
   logic                    burst_reject;
   logic                    sat_flag;
   logic                    locked;

   modport master (
      output burst_active, error_in, kp_shift, ki_shift, hold, clear_int,
      input  offset_out, offset_valid, burst_reject, sat_flag, locked
   );

   modport slave (
      input  burst_active, error_in, kp_shift, ki_shift, hold, clear_int,
      output offset_out, offset_valid, burst_reject, sat_flag, locked
   );
endinterface

// File: rtl/pi_loop_filter_gen.sv
// Burst-gated PI loop filter: sums burst phase error, updates a saturating integrator
// and emits a clamped NCO offset once per accepted burst. Lock detect: PI_LOOP_LOCK_EN.
module pi_loop_filter_gen #(
   parameter int ERR_W       = 12,
   parameter int CNT_W       = 7,
   parameter int ACC_W       = 24,
   parameter int INT_W       = 32,
   parameter int OUT_W       = 32,
   parameter int MIN_SAMPLES = 8,
   parameter int LOCK_THRESH = 64,
   parameter int LOCK_LINES  = 16
) (
   input  logic clk,
   input  logic rst_n,
   pi_loop_filter_gen_if.slave bus
);
   localparam int MW0 = (ACC_W > INT_W) ? ACC_W : INT_W;
   localparam int MW1 = (MW0 > OUT_W) ? MW0 : OUT_W;
   localparam int CW  = MW1 + 2;

   localparam logic [CNT_W-1:0]    CNT_MAX = '1;
   localparam logic [CNT_W-1:0]    MIN_CNT = CNT_W'(MIN_SAMPLES);
   localparam logic signed [CW-1:0] INT_MAX = {{(CW-INT_W+1){1'b0}}, {(INT_W-1){1'b1}}};
   localparam logic signed [CW-1:0] INT_MIN = -INT_MAX;
   localparam logic signed [CW-1:0] OUT_MAX = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [CW-1:0] OUT_MIN = -OUT_MAX;

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_EVAL, S_UPDATE} state_t;

   state_t                  state_q;
   logic signed [ACC_W-1:0] acc_q;
   logic [CNT_W-1:0]        cnt_q;
   logic signed [ACC_W-1:0] cap_err_q;
   logic [CNT_W-1:0]        cap_cnt_q;
   logic signed [INT_W-1:0] int_q;
   logic [4:0]              kp_q;
   logic [4:0]              ki_q;
   logic signed [OUT_W-1:0] offset_q;
   logic                    valid_q;
   logic                    reject_q;
   logic                    sat_q;

   logic signed [ERR_W-1:0] err;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [CW-1:0]    int_sum;
   logic signed [CW-1:0]    p_term;
   logic signed [CW-1:0]    i_term;
   logic signed [CW-1:0]    off_sum;
   logic signed [INT_W-1:0] int_d;
   logic signed [OUT_W-1:0] off_d;
   logic                    int_clamp;
   logic                    off_clamp;

   assign err = bus.error_in;

   // All arithmetic runs in a common width wide enough that sums never wrap before clamping.
   always_comb begin
      acc_d     = acc_q + ACC_W'(err);
      int_sum   = CW'(int_q) + CW'(cap_err_q);
      int_d     = int_sum[INT_W-1:0];
      int_clamp = 1'b0;
      if (int_sum > INT_MAX) begin
         int_d     = INT_MAX[INT_W-1:0];
         int_clamp = 1'b1;
      end else if (int_sum < INT_MIN) begin
         int_d     = INT_MIN[INT_W-1:0];
         int_clamp = 1'b1;
      end
      p_term    = CW'(cap_err_q) >>> kp_q;
      i_term    = CW'(int_q) >>> ki_q;
      off_sum   = p_term + i_term;
      off_d     = off_sum[OUT_W-1:0];
      off_clamp = 1'b0;
      if (off_sum > OUT_MAX) begin
         off_d     = OUT_MAX[OUT_W-1:0];
         off_clamp = 1'b1;
      end else if (off_sum < OUT_MIN) begin
         off_d     = OUT_MIN[OUT_W-1:0];
         off_clamp = 1'b1;
      end
   end

`ifdef PI_LOOP_LOCK_EN
   localparam int LW = $clog2(LOCK_LINES + 1);
   localparam logic [LW-1:0]        LOCK_MAX = LW'(LOCK_LINES);
   localparam logic signed [ACC_W:0] LOCK_TH  = (ACC_W+1)'(LOCK_THRESH);

   logic [LW-1:0]        lock_cnt_q;
   logic                 locked_q;
   logic signed [ACC_W:0] cap_ext;
   logic                 lock_good;

   always_comb begin
      cap_ext   = {cap_err_q[ACC_W-1], cap_err_q};
      lock_good = (cap_ext < LOCK_TH) && (cap_ext > -LOCK_TH);
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         acc_q      <= '0;
         cnt_q      <= '0;
         cap_err_q  <= '0;
         cap_cnt_q  <= '0;
         int_q      <= '0;
         kp_q       <= '0;
         ki_q       <= '0;
         offset_q   <= '0;
         valid_q    <= 1'b0;
         reject_q   <= 1'b0;
         sat_q      <= 1'b0;
`ifdef PI_LOOP_LOCK_EN
         lock_cnt_q <= '0;
         locked_q   <= 1'b0;
`endif
      end else begin
         valid_q  <= 1'b0;
         reject_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.burst_active) begin
                  acc_q   <= ACC_W'(err);
                  cnt_q   <= CNT_W'(1);
                  state_q <= S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (bus.burst_active) begin
                  if (cnt_q != CNT_MAX) begin
                     acc_q <= acc_d;
                     cnt_q <= cnt_q + 1'b1;
                  end
               end else begin
                  cap_err_q <= acc_q;
                  cap_cnt_q <= cnt_q;
                  acc_q     <= '0;
                  cnt_q     <= '0;
                  state_q   <= S_EVAL;
               end
            end
            S_EVAL: begin
               if (cap_cnt_q < MIN_CNT) begin
                  reject_q <= 1'b1;
                  state_q  <= S_IDLE;
               end else begin
                  kp_q <= bus.kp_shift;
                  ki_q <= bus.ki_shift;
                  if (!bus.hold) begin
                     int_q <= int_d;
                     if (int_clamp) sat_q <= 1'b1;
                  end
`ifdef PI_LOOP_LOCK_EN
                  if (lock_good) begin
                     if (lock_cnt_q != LOCK_MAX) lock_cnt_q <= lock_cnt_q + 1'b1;
                     locked_q <= (lock_cnt_q >= LOCK_MAX - 1'b1);
                  end else begin
                     lock_cnt_q <= '0;
                     locked_q   <= 1'b0;
                  end
`endif
                  state_q <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               offset_q <= off_d;
               valid_q  <= 1'b1;
               if (off_clamp) sat_q <= 1'b1;
               state_q  <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
         // Clear is last so it wins over any integrator/flag update on the same edge.
         if (bus.clear_int) begin
            int_q <= '0;
            sat_q <= 1'b0;
`ifdef PI_LOOP_LOCK_EN
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
`endif
         end
      end
   end

   assign bus.offset_out   = offset_q;
   assign bus.offset_valid = valid_q;
   assign bus.burst_reject = reject_q;
   assign bus.sat_flag     = sat_q;
`ifdef PI_LOOP_LOCK_EN
   assign bus.locked       = locked_q;
`else
   assign bus.locked       = 1'b0;
`endif
endmodule

// File: tb/tb_pi_loop_filter_gen.sv
// Randomised + directed bench for pi_loop_filter_gen: a default instance and a narrow
// (INT_W=16, OUT_W=16) instance share one stimulus and are checked against a burst-level model.
module tb_pi_loop_filter_gen;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pi_loop_filter_gen_if #(.ERR_W(12), .OUT_W(32)) bus_a ();
   pi_loop_filter_gen_if #(.ERR_W(12), .OUT_W(16)) bus_b ();

   pi_loop_filter_gen #(.ERR_W(12), .INT_W(32), .OUT_W(32)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a));
   pi_loop_filter_gen #(.ERR_W(12), .INT_W(16), .OUT_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b));

   assign bus_b.burst_active = bus_a.burst_active;
   assign bus_b.error_in     = bus_a.error_in;
   assign bus_b.kp_shift     = bus_a.kp_shift;
   assign bus_b.ki_shift     = bus_a.ki_shift;
   assign bus_b.hold         = bus_a.hold;
   assign bus_b.clear_int    = bus_a.clear_int;

   int vectors = 0;
   int miscompares = 0;

   // Burst-level reference state, index 0 = default instance, 1 = narrow instance.
   longint m_int [2];
   longint m_out [2];
   bit     m_sat [2];
   int     m_lc  [2];
   int     IW    [2] = '{32, 16};
   int     OW    [2] = '{32, 16};

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint sat(input longint v, input int w, output bit clamped);
      longint mx = (64'sd1 <<< (w - 1)) - 1;
      clamped = 1'b0;
      if (v > mx) begin clamped = 1'b1; return mx; end
      if (v < -mx) begin clamped = 1'b1; return -mx; end
      return v;
   endfunction

   function automatic logic exp_lock(input int k);
`ifdef PI_LOOP_LOCK_EN
      return m_lc[k] == 16;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_int[k] = 0; m_out[k] = 0; m_sat[k] = 1'b0; m_lc[k] = 0;
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         m_int[k] = 0; m_sat[k] = 1'b0; m_lc[k] = 0;
      end
   endtask

   task automatic check_status(input string tag);
      check({tag, "_out_a"}, bus_a.offset_out, m_out[0]);
      check({tag, "_out_b"}, bus_b.offset_out, m_out[1]);
      check({tag, "_sat_a"}, bus_a.sat_flag, m_sat[0]);
      check({tag, "_sat_b"}, bus_b.sat_flag, m_sat[1]);
      check({tag, "_lock_a"}, bus_a.locked, exp_lock(0));
      check({tag, "_lock_b"}, bus_b.locked, exp_lock(1));
   endtask

   task automatic check_zero(input string tag);
      check_status(tag);
      check({tag, "_val_a"}, bus_a.offset_valid, 1'b0);
      check({tag, "_val_b"}, bus_b.offset_valid, 1'b0);
      check({tag, "_rej_a"}, bus_a.burst_reject, 1'b0);
      check({tag, "_rej_b"}, bus_b.burst_reject, 1'b0);
   endtask

   // Enters and leaves just after a rising edge. clr_at >= 0 pulses clear_int on that sample.
   task automatic run_burst(input string tag, input int n, input int val, input bit rnd,
                            input logic [4:0] kp, input logic [4:0] ki, input bit hld,
                            input int clr_at);
      logic signed [11:0] e;
      longint sum = 0;
      int     cnt = 0;
      bit     accepted, c;
      bus_a.kp_shift = kp;
      bus_a.ki_shift = ki;
      bus_a.hold     = hld;
      for (int s = 0; s < n; s++) begin
         e = rnd ? 12'($urandom) : 12'(val);
         bus_a.burst_active = 1'b1;
         bus_a.error_in     = e;
         bus_a.clear_int    = (s == clr_at);
         if (cnt < 127) begin sum += longint'(e); cnt++; end
         @(posedge clk); #1;
         if (s == clr_at) begin
            bus_a.clear_int = 1'b0;
            model_clear();
            check({tag, "_clr_sat_a"}, bus_a.sat_flag, 1'b0);
            check({tag, "_clr_sat_b"}, bus_b.sat_flag, 1'b0);
         end
      end
      bus_a.burst_active = 1'b0;
      bus_a.error_in     = '0;
      @(posedge clk);
      @(posedge clk);
      accepted = (cnt >= 8);
      if (accepted) begin
         for (int k = 0; k < 2; k++) begin
            if (!hld) begin
               m_int[k] = sat(m_int[k] + sum, IW[k], c);
               if (c) m_sat[k] = 1'b1;
            end
            m_out[k] = sat((sum >>> kp) + (m_int[k] >>> ki), OW[k], c);
            if (c) m_sat[k] = 1'b1;
`ifdef PI_LOOP_LOCK_EN
            if (sum < 64 && sum > -64) begin
               if (m_lc[k] < 16) m_lc[k]++;
            end else m_lc[k] = 0;
`endif
         end
      end
      @(negedge clk);
      check({tag, "_rej_a"}, bus_a.burst_reject, !accepted);
      check({tag, "_rej_b"}, bus_b.burst_reject, !accepted);
      check({tag, "_early_val"}, bus_a.offset_valid, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_val_a"}, bus_a.offset_valid, accepted);
      check({tag, "_val_b"}, bus_b.offset_valid, accepted);
      check({tag, "_rej_end"}, bus_a.burst_reject, 1'b0);
      check_status(tag);
      @(posedge clk); #1;
      check({tag, "_val_off"}, bus_a.offset_valid, 1'b0);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_zero("rst");
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bus_a.burst_active = 1'b0;
      bus_a.error_in     = '0;
      bus_a.kp_shift     = 5'd4;
      bus_a.ki_shift     = 5'd6;
      bus_a.hold         = 1'b0;
      bus_a.clear_int    = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_burst("b20", 20, 16, 1'b0, 5'd4, 5'd6, 1'b0, -1);
      check("b20_out25", bus_a.offset_out, 25);
      run_burst("hold", 20, 16, 1'b0, 5'd4, 5'd6, 1'b1, -1);
      check("hold_out25", bus_a.offset_out, 25);
      run_burst("b20r", 20, 16, 1'b0, 5'd4, 5'd6, 1'b0, -1);
      check("b20r_out30", bus_a.offset_out, 30);
      run_burst("short5", 5, 16, 1'b0, 5'd4, 5'd6, 1'b0, -1);
      run_burst("min8", 8, -3, 1'b0, 5'd0, 5'd31, 1'b0, -1);
      run_burst("cap", 140, 2047, 1'b0, 5'd31, 5'd0, 1'b0, -1);

      pulse_reset();
      for (int i = 0; i < 3; i++)
         run_burst("sat", 100, 127, 1'b0, 5'd4, 5'd6, 1'b0, -1);
      check("sat_flag_b", bus_b.sat_flag, 1'b1);
      check("sat_out_b", bus_b.offset_out, 793 + 511);
      run_burst("clr", 20, 16, 1'b0, 5'd4, 5'd6, 1'b0, 5);

      for (int s = 0; s < 6; s++) begin
         bus_a.burst_active = 1'b1;
         bus_a.error_in     = 12'sd50;
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      model_reset();
      check_zero("rst_mid");
      bus_a.burst_active = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_burst("post_rst", 20, 16, 1'b0, 5'd4, 5'd6, 1'b0, -1);
      check("post_rst_out25", bus_a.offset_out, 25);

      pulse_reset();
      for (int i = 0; i < 16; i++)
         run_burst("lock", 10, 2, 1'b0, 5'd4, 5'd6, 1'b0, -1);
`ifdef PI_LOOP_LOCK_EN
      check("lock16", bus_a.locked, 1'b1);
`endif
      run_burst("unlock", 10, 10, 1'b0, 5'd4, 5'd6, 1'b0, -1);
      check("unlock0", bus_a.locked, 1'b0);

      for (int i = 0; i < 40; i++) begin
         run_burst("rnd", int'($urandom_range(1, 140)), 0, 1'b1,
                   5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 6)) : -1);
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, expected finish before 2000000");
      $fatal(1, "timeout");
   end
endmodule
